// File: rtl/spu_controller.sv
// spu_controller: multicycle sequencer for spu_datapath.
// It fetches a 16-bit instruction, decodes it, and spends one execute cycle driving the
// datapath controls. A taken JMPZ adds one extra cycle for the PC update.
// Instruction fields: op=IR[15:12], ra=IR[11:8], rb=IR[7:4], rc=IR[3:0], imm8=IR[7:0].
// Ports:
//   clk, rst (async active-low), start       control inputs
//   halted                                    high while in HALT
//   i_addr, i_rd, i_data                      instruction memory (combinational read)
//   d_addr, d_rd, d_wr                        data memory strobes
//   rf_w_addr/wr, rf_rp_addr/rd, rf_rq_addr/rd register file controls
//   rf_s1/rf_s0, alu_s1/alu_s0, loac          write-mux select, ALU select, constant
//   pco_en                                    rf port-p data == 0, used by JMPZ
// All outputs are a Moore decode of the state register and IR.
module spu_controller #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned DM_AW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             halted,
  output logic [PC_W-1:0]  i_addr,
  output logic             i_rd,
  input  logic [15:0]      i_data,
  output logic [DM_AW-1:0] d_addr,
  output logic             d_rd,
  output logic             d_wr,
  output logic [3:0]       rf_w_addr,
  output logic             rf_w_wr,
  output logic [3:0]       rf_rp_addr,
  output logic             rf_rp_rd,
  output logic [3:0]       rf_rq_addr,
  output logic             rf_rq_rd,
  output logic             rf_s1,
  output logic             rf_s0,
  output logic             alu_s1,
  output logic             alu_s0,
  output logic [7:0]       loac,
  input  logic             pco_en
);

  localparam int unsigned XW = (PC_W > 8) ? PC_W : 8;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_LOAD, S_STORE, S_ADD,
    S_LOADC, S_SUB, S_JMPZ, S_JMP, S_HALT
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;

  logic [3:0] op, ra, rb, rc;
  logic [7:0] imm8;
  assign op   = ir_q[15:12];
  assign ra   = ir_q[11:8];
  assign rb   = ir_q[7:4];
  assign rc   = ir_q[3:0];
  assign imm8 = ir_q[7:0];

  // PC already points one past the JMPZ, so the relative target needs a -1.
  logic [XW-1:0]   off_ext, jmp_sum;
  logic [PC_W-1:0] jmp_tgt;
  assign off_ext = XW'($signed(imm8));
  assign jmp_sum = XW'(pc_q) + off_ext - XW'(1);
  assign jmp_tgt = jmp_sum[PC_W-1:0];

  // State, PC and IR registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state, PC and IR update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_IDLE: begin
        pc_d = '0;
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_d    = i_data;
        pc_d    = pc_q + PC_W'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (op)
          4'd0:    state_d = S_LOAD;
          4'd1:    state_d = S_STORE;
          4'd2:    state_d = S_ADD;
          4'd3:    state_d = S_LOADC;
          4'd4:    state_d = S_SUB;
          4'd5:    state_d = S_JMPZ;
          default: state_d = S_HALT;
        endcase
      end
      S_LOAD, S_STORE, S_ADD, S_LOADC, S_SUB: state_d = S_FETCH;
      S_JMPZ: state_d = pco_en ? S_JMP : S_FETCH;
      S_JMP: begin
        pc_d    = jmp_tgt;
        state_d = S_FETCH;
      end
      S_HALT: begin
        if (start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode; IDLE (the reset state) drives everything to 0.
  always_comb begin
    halted     = 1'b0;
    i_addr     = '0;
    i_rd       = 1'b0;
    d_addr     = '0;
    d_rd       = 1'b0;
    d_wr       = 1'b0;
    rf_w_addr  = '0;
    rf_w_wr    = 1'b0;
    rf_rp_addr = '0;
    rf_rp_rd   = 1'b0;
    rf_rq_addr = '0;
    rf_rq_rd   = 1'b0;
    rf_s1      = 1'b0;
    rf_s0      = 1'b0;
    alu_s1     = 1'b0;
    alu_s0     = 1'b0;
    loac       = '0;
    case (state_q)
      S_FETCH: begin
        i_rd   = 1'b1;
        i_addr = pc_q;
      end
      S_LOAD: begin
        d_addr    = DM_AW'(imm8);
        d_rd      = 1'b1;
        rf_s0     = 1'b1;
        rf_w_addr = ra;
        rf_w_wr   = 1'b1;
      end
      S_STORE: begin
        d_addr     = DM_AW'(imm8);
        d_wr       = 1'b1;
        rf_rp_addr = ra;
        rf_rp_rd   = 1'b1;
      end
      S_ADD, S_SUB: begin
        rf_rp_addr = rb;
        rf_rp_rd   = 1'b1;
        rf_rq_addr = rc;
        rf_rq_rd   = 1'b1;
        alu_s0     = (state_q == S_ADD);
        alu_s1     = (state_q == S_SUB);
        rf_w_addr  = ra;
        rf_w_wr    = 1'b1;
      end
      S_LOADC: begin
        rf_s1     = 1'b1;
        loac      = imm8;
        rf_w_addr = ra;
        rf_w_wr   = 1'b1;
      end
      S_JMPZ: begin
        rf_rp_addr = ra;
        rf_rp_rd   = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spu_controller.sv
// Self-checking bench for spu_controller: directed programs plus a random program,
// checked cycle by cycle against an instruction-level reference model.
module tb_spu_controller;

  typedef struct packed {
    logic       halted;
    logic [7:0] i_addr;
    logic       i_rd;
    logic [7:0] d_addr;
    logic       d_rd;
    logic       d_wr;
    logic [3:0] w_addr;
    logic       w_wr;
    logic [3:0] rp_addr;
    logic       rp_rd;
    logic [3:0] rq_addr;
    logic       rq_rd;
    logic       rf_s1;
    logic       rf_s0;
    logic       alu_s1;
    logic       alu_s0;
    logic [7:0] loac;
  } out_t;

  logic clk, rst, start, pco_en;
  logic halted, i_rd, d_rd, d_wr, rf_w_wr, rf_rp_rd, rf_rq_rd;
  logic rf_s1, rf_s0, alu_s1, alu_s0;
  logic [7:0] i_addr, d_addr, loac;
  logic [15:0] i_data;
  logic [3:0] rf_w_addr, rf_rp_addr, rf_rq_addr;

  logic [15:0] imem [256];
  assign i_data = imem[i_addr];

  spu_controller dut (
    .clk(clk), .rst(rst), .start(start), .halted(halted),
    .i_addr(i_addr), .i_rd(i_rd), .i_data(i_data),
    .d_addr(d_addr), .d_rd(d_rd), .d_wr(d_wr),
    .rf_w_addr(rf_w_addr), .rf_w_wr(rf_w_wr),
    .rf_rp_addr(rf_rp_addr), .rf_rp_rd(rf_rp_rd),
    .rf_rq_addr(rf_rq_addr), .rf_rq_rd(rf_rq_rd),
    .rf_s1(rf_s1), .rf_s0(rf_s0), .alu_s1(alu_s1), .alu_s0(alu_s0),
    .loac(loac), .pco_en(pco_en)
  );

  out_t obs;
  assign obs = {halted, i_addr, i_rd, d_addr, d_rd, d_wr, rf_w_addr, rf_w_wr,
                rf_rp_addr, rf_rp_rd, rf_rq_addr, rf_rq_rd,
                rf_s1, rf_s0, alu_s1, alu_s0, loac};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] pc_m;   // architectural PC of the reference model
  int pco_mode;       // 0/1 force pco_en at JMPZ, 2 random

  task automatic chk(input out_t exp, input string tag);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // Check this cycle's outputs, then advance to the next falling edge.
  task automatic step(input out_t exp, input string tag);
    chk(exp, tag);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic out_t fetch_exp(input logic [7:0] pc);
    out_t e = '0;
    e.i_rd   = 1'b1;
    e.i_addr = pc;
    return e;
  endfunction

  // Expected controls in the execute cycle of an instruction word.
  function automatic out_t exec_exp(input logic [15:0] ins);
    out_t e = '0;
    logic [3:0] ra = ins[11:8];
    logic [3:0] rb = ins[7:4];
    logic [3:0] rc = ins[3:0];
    logic [7:0] imm = ins[7:0];
    case (ins[15:12])
      4'd0: begin e.d_addr = imm; e.d_rd = 1; e.rf_s0 = 1; e.w_addr = ra; e.w_wr = 1; end
      4'd1: begin e.d_addr = imm; e.d_wr = 1; e.rp_addr = ra; e.rp_rd = 1; end
      4'd2, 4'd4: begin
        e.rp_addr = rb; e.rp_rd = 1; e.rq_addr = rc; e.rq_rd = 1;
        e.w_addr = ra; e.w_wr = 1;
        if (ins[15:12] == 4'd2) e.alu_s0 = 1; else e.alu_s1 = 1;
      end
      4'd3: begin e.rf_s1 = 1; e.loac = imm; e.w_addr = ra; e.w_wr = 1; end
      4'd5: begin e.rp_addr = ra; e.rp_rd = 1; end
      default: ;
    endcase
    return e;
  endfunction

  // Execute one instruction from the model PC, checking every cycle it spans.
  task automatic run_one(input string tag);
    logic [15:0] ins;
    logic [7:0]  jaddr;
    logic        p;
    out_t        e;
    int          n;
    ins   = imem[pc_m];
    start = 1'($urandom);
    pco_en = 1'($urandom);
    step(fetch_exp(pc_m), {tag, "_fetch"});
    jaddr = pc_m;
    pc_m  = pc_m + 8'd1;
    start = 1'($urandom);
    step('0, {tag, "_decode"});
    if (ins[15:12] <= 4'd5) begin
      p = (pco_mode == 2) ? 1'($urandom) : 1'(pco_mode);
      pco_en = p;
      start  = 1'($urandom);
      step(exec_exp(ins), {tag, "_exec"});
      if (ins[15:12] == 4'd5 && p) begin
        start = 1'($urandom);
        step('0, {tag, "_jmp"});
        pc_m = jaddr + ins[7:0];   // 8-bit wrap equals sign-extended offset
      end
    end else begin
      e = '0;
      e.halted = 1'b1;
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        start = 1'b0;
        step(e, {tag, "_halt"});
      end
      start = 1'b1;
      step(e, {tag, "_halt_exit"});
      step('0, {tag, "_idle"});
      pc_m = 8'd0;
    end
  endtask

  initial begin
    logic [3:0] op;
    rst = 1'b0;
    start = 1'b1;
    pco_en = 1'b1;
    pco_mode = 2;
    pc_m = 8'd0;
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
    imem[0] = 16'h3105;  // LOADC r1,#5
    imem[1] = 16'h3203;  // LOADC r2,#3
    imem[2] = 16'h4312;  // SUB r3,r1,r2
    imem[3] = 16'h1310;  // STORE r3->d[0x10]
    imem[4] = 16'h0420;  // LOAD r4<-d[0x20]
    imem[5] = 16'h50FE;  // JMPZ r0,-2
    imem[6] = 16'hF000;  // undefined -> HALT

    repeat (3) @(negedge clk);
    chk('0, "reset_hold");
    rst = 1'b1;
    step('0, "idle_start");

    for (int k = 0; k < 5; k++) run_one("dir");
    pco_mode = 1; run_one("jmpz_taken");      // -> PC 3
    pco_mode = 2; run_one("dir_store2");
    run_one("dir_load2");
    pco_mode = 0; run_one("jmpz_not_taken");  // -> PC 6
    pco_mode = 2; run_one("dir_halt");

    // Mid FETCH at PC 0: swap in a random program whose first word is JMPZ -1.
    for (int i = 0; i < 256; i++) begin
      op = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
      imem[i] = {op, 12'($urandom)};
    end
    imem[0] = 16'h50FF;
    pco_mode = 1; run_one("jmpz_wrap");
    pco_mode = 2;
    for (int k = 0; k < 350; k++) run_one("rnd");

    // Asynchronous reset mid-FETCH.
    rst = 1'b0;
    #1 chk('0, "rst_async");
    @(negedge clk);
    imem[0] = 16'h0420;
    rst = 1'b1;
    start = 1'b1;
    step('0, "idle_after_rst");
    step(fetch_exp(8'd0), "load_fetch");
    step('0, "load_decode");
    chk(exec_exp(16'h0420), "load_exec");
    rst = 1'b0;
    #1 chk('0, "load_rst_drop");
    @(negedge clk);
    chk('0, "load_rst_hold");
    rst = 1'b1;
    start = 1'b0;
    step('0, "idle_hold");
    start = 1'b1;
    step('0, "idle_go");
    chk(fetch_exp(8'd0), "refetch_pc0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
